edge_to_level: RTL and testbench

EDGE_TO_LEVEL -- requirements
Module: edge_to_level

---
 rtl/edge_to_level.sv | 140 ++++++++++++++
 tb/tb_edge_to_level.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/edge_to_level.sv
// edge_to_level: regenerates a level signal from single-cycle rise/fall/toggle
// requests. Every applied level value is held for at least HOLD cycles; one
// change arriving during the hold window is buffered and applied at expiry.
// Conflicting requests (rise together with fall) are discarded and flagged on drop.
module edge_to_level #(
  parameter int HOLD = 4,
  parameter int CW   = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rise_req,
  input  logic       fall_req,
  input  logic       tog_req,
  output logic       level,
  output logic       busy,
  output logic       pend,
  output logic       drop,
  output logic [7:0] chg_cnt
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } state_t;

  localparam logic [CW-1:0] CNT_RELOAD = CW'(HOLD - 1);
  localparam logic [CW-1:0] CNT_ONE    = CW'(1);
  localparam logic [CW-1:0] CNT_ZERO   = CW'(0);

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic          r_level;
  logic          r_pend;
  logic          r_pend_val;
  logic          r_drop;
  logic [7:0]    r_chg_cnt;

  logic          w_conflict;
  logic          w_has_tgt;
  logic          w_tgt_val;
  logic          w_eff;
  logic          w_differ;

  // Decode the sampled requests into a target level and compare it with the
  // effective level (the buffered value when one exists, else the output).
  always_comb begin
    w_conflict = rise_req & fall_req;
    w_eff      = r_pend ? r_pend_val : r_level;
    w_has_tgt  = 1'b0;
    w_tgt_val  = 1'b0;
    if (w_conflict) begin
      w_has_tgt = 1'b0;
      w_tgt_val = 1'b0;
    end else if (rise_req) begin
      w_has_tgt = 1'b1;
      w_tgt_val = 1'b1;
    end else if (fall_req) begin
      w_has_tgt = 1'b1;
      w_tgt_val = 1'b0;
    end else if (tog_req) begin
      w_has_tgt = 1'b1;
      w_tgt_val = ~w_eff;
    end else begin
      w_has_tgt = 1'b0;
      w_tgt_val = 1'b0;
    end
    w_differ = w_has_tgt & (w_tgt_val != w_eff);
  end

  // Hold-window state machine: applies, buffers or cancels level changes and
  // keeps the change counter and the conflict pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_cnt      <= CNT_ZERO;
      r_level    <= 1'b0;
      r_pend     <= 1'b0;
      r_pend_val <= 1'b0;
      r_drop     <= 1'b0;
      r_chg_cnt  <= 8'd0;
    end else begin
      r_drop <= w_conflict;
      case (r_state)
        ST_IDLE: begin
          if (w_differ) begin
            r_level   <= w_tgt_val;
            r_cnt     <= CNT_RELOAD;
            r_chg_cnt <= r_chg_cnt + 8'd1;
            r_state   <= ST_HOLD;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_HOLD: begin
          if (r_cnt != CNT_ZERO) begin
            // Window still running: buffer the first differing change, a
            // second differing change (back to the current level) cancels it.
            r_cnt <= r_cnt - CNT_ONE;
            if (w_differ) begin
              if (!r_pend) begin
                r_pend     <= 1'b1;
                r_pend_val <= w_tgt_val;
              end else begin
                r_pend <= 1'b0;
              end
            end
          end else if (r_pend) begin
            // Expiry with a buffered change: apply it, and judge any request
            // in this cycle against the newly applied level.
            r_level   <= r_pend_val;
            r_cnt     <= CNT_RELOAD;
            r_chg_cnt <= r_chg_cnt + 8'd1;
            if (w_differ) begin
              r_pend     <= 1'b1;
              r_pend_val <= w_tgt_val;
            end else begin
              r_pend <= 1'b0;
            end
          end else if (w_differ) begin
            r_level   <= w_tgt_val;
            r_cnt     <= CNT_RELOAD;
            r_chg_cnt <= r_chg_cnt + 8'd1;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign level   = r_level;
  assign busy    = (r_state == ST_HOLD);
  assign pend    = r_pend;
  assign drop    = r_drop;
  assign chg_cnt = r_chg_cnt;

endmodule

// File: tb/tb_edge_to_level.sv
// Scoreboard bench for edge_to_level (HOLD=4): the stimulus process pushes
// the hand-computed expected outputs after each edge, a monitor pops and
// compares them on the following falling edge.
module tb_edge_to_level;

  logic       clk;
  logic       rst_n;
  logic       rise_req;
  logic       fall_req;
  logic       tog_req;
  logic       level;
  logic       busy;
  logic       pend;
  logic       drop;
  logic [7:0] chg_cnt;

  typedef struct {
    string      name;
    logic [11:0] exp;
  } item_t;

  item_t q[$];
  int    n_checks;
  int    n_fail;

  edge_to_level #(.HOLD(4), .CW(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .rise_req (rise_req),
    .fall_req (fall_req),
    .tog_req  (tog_req),
    .level    (level),
    .busy     (busy),
    .pend     (pend),
    .drop     (drop),
    .chg_cnt  (chg_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [11:0] pack(input logic l, input logic b, input logic p,
                                       input logic d, input logic [7:0] c);
    return {l, b, p, d, c};
  endfunction

  function automatic void check(input string name, input logic [11:0] act, input logic [11:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got lvl/busy/pend/drop=%b chg=%0d, want lvl/busy/pend/drop=%b chg=%0d",
               name, act[11:8], act[7:0], exp[11:8], exp[7:0]);
    end
  endfunction

  // Monitor: compare DUT outputs against the oldest expectation, mid-cycle.
  always @(negedge clk) begin
    if (q.size() > 0) begin
      item_t it;
      it = q.pop_front();
      check(it.name, pack(level, busy, pend, drop, chg_cnt), it.exp);
    end
  end

  // Drive one cycle of requests, then queue the outputs expected after the edge.
  task automatic step(input string name, input logic r, input logic f, input logic t,
                      input logic l, input logic b, input logic p, input logic d,
                      input logic [7:0] c);
    item_t it;
    rise_req = r;
    fall_req = f;
    tog_req  = t;
    @(posedge clk);
    #1;
    rise_req = 1'b0;
    fall_req = 1'b0;
    tog_req  = 1'b0;
    it.name = name;
    it.exp  = pack(l, b, p, d, c);
    q.push_back(it);
  endtask

  // Several idle cycles with the same expected outputs.
  task automatic idle(input string name, input int n, input logic l, input logic b,
                      input logic p, input logic [7:0] c);
    for (int i = 0; i < n; i++) step(name, 1'b0, 1'b0, 1'b0, l, b, p, 1'b0, c);
  endtask

  // Watchdog so the run can never hang.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    rise_req = 1'b0;
    fall_req = 1'b0;
    tog_req  = 1'b0;
    #2;
    check("reset_state", pack(level, busy, pend, drop, chg_cnt), pack(1'b0, 1'b0, 1'b0, 1'b0, 8'd0));
    #6;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single rise from idle, hold 4 cycles.
    step("a_rise", 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd1);
    idle("a_hold", 3, 1'b1, 1'b1, 1'b0, 8'd1);
    idle("a_idle", 1, 1'b1, 1'b0, 1'b0, 8'd1);

    // Fall from idle.
    step("b_fall", 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd2);
    idle("b_hold", 3, 1'b0, 1'b1, 1'b0, 8'd2);
    idle("b_idle", 1, 1'b0, 1'b0, 1'b0, 8'd2);

    // Rise then fall: fall is buffered and applied at expiry.
    step("c_rise", 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd3);
    step("c_fall_buf", 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'd3);
    idle("c_wait", 2, 1'b1, 1'b1, 1'b1, 8'd3);
    idle("c_apply", 1, 1'b0, 1'b1, 1'b0, 8'd4);
    idle("c_hold2", 3, 1'b0, 1'b1, 1'b0, 8'd4);
    idle("c_idle", 1, 1'b0, 1'b0, 1'b0, 8'd4);

    // Rise, fall, rise: buffer cancelled, level stays 1.
    step("d_rise", 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd5);
    step("d_fall_buf", 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'd5);
    step("d_cancel", 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd5);
    idle("d_hold", 1, 1'b1, 1'b1, 1'b0, 8'd5);
    idle("d_idle", 1, 1'b1, 1'b0, 1'b0, 8'd5);

    // Back to 0, then conflict and no-op fall.
    step("e_fall", 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd6);
    idle("e_hold", 3, 1'b0, 1'b1, 1'b0, 8'd6);
    idle("e_idle", 1, 1'b0, 1'b0, 1'b0, 8'd6);
    step("e_conflict", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'd6);
    idle("e_drop_clr", 1, 1'b0, 1'b0, 1'b0, 8'd6);
    step("e_noop_fall", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd6);

    // Two toggles: second is buffered as 0.
    step("f_tog1", 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'd7);
    step("f_tog2_buf", 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 8'd7);
    idle("f_wait", 2, 1'b1, 1'b1, 1'b1, 8'd7);
    idle("f_apply", 1, 1'b0, 1'b1, 1'b0, 8'd8);
    idle("f_hold2", 3, 1'b0, 1'b1, 1'b0, 8'd8);
    idle("f_idle", 1, 1'b0, 1'b0, 1'b0, 8'd8);

    // Toggle at expiry with a buffered change: judged against the new level.
    step("g_rise", 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd9);
    step("g_fall_buf", 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'd9);
    idle("g_wait", 2, 1'b1, 1'b1, 1'b1, 8'd9);
    step("g_tog_expiry", 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8'd10);
    idle("g_wait2", 3, 1'b0, 1'b1, 1'b1, 8'd10);
    idle("g_apply2", 1, 1'b1, 1'b1, 1'b0, 8'd11);
    idle("g_hold3", 3, 1'b1, 1'b1, 1'b0, 8'd11);
    idle("g_idle", 1, 1'b1, 1'b0, 1'b0, 8'd11);

    // Same-as-effective request during hold is a no-op; new request at expiry applies.
    step("h_fall", 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd12);
    step("h_noop_hold", 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd12);
    idle("h_hold", 2, 1'b0, 1'b1, 1'b0, 8'd12);
    step("h_rise_expiry", 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd13);
    idle("h_hold2", 3, 1'b1, 1'b1, 1'b0, 8'd13);
    idle("h_idle", 1, 1'b1, 1'b0, 1'b0, 8'd13);

    // Asynchronous reset mid-hold with a buffered change.
    step("r_fall", 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd14);
    step("r_rise_buf", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'd14);
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("async_reset", pack(level, busy, pend, drop, chg_cnt), pack(1'b0, 1'b0, 1'b0, 1'b0, 8'd0));
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // First edge after reset behaves as idle; then 255 more changes wrap chg_cnt.
    step("w_rise", 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd1);
    idle("w_hold", 3, 1'b1, 1'b1, 1'b0, 8'd1);
    for (int k = 2; k <= 256; k++) begin
      logic [8:0] kk;
      kk = 9'(k);
      step("w_tog", 1'b0, 1'b0, 1'b1, kk[0], 1'b1, 1'b0, 1'b0, kk[7:0]);
      idle("w_hold", 3, kk[0], 1'b1, 1'b0, kk[7:0]);
    end
    idle("w_wrapped_idle", 1, 1'b0, 1'b0, 1'b0, 8'd0);

    // Let the monitor drain the scoreboard within a bounded number of cycles.
    for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
    if (q.size() > 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: %0d expectations left unchecked, want 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
